// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: SRAM-like data-bus controller for MEM-stage loads/stores (IDLE -> ADDR -> DATA).
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses on adel/ades.
module mem_access_ctrl #(
    parameter int unsigned KSEG_XLATE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        adel,
    output logic        ades,
    output logic        stall
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic        kill_q;
    logic        resp_valid_q;

    logic        opKnown;
    logic        opStore;
    logic [1:0]  opSize;
    logic [31:0] opWdata;
    logic [31:0] opAddr;
    logic [3:0]  opWstrb;
    logic        misalignTrap;
    logic        accept;
    logic        busStart;
    logic        complete;

    // Decode the incoming request into bus size, replicated data, strobes and physical address.
    always_comb begin
        opKnown = 1'b1;
        opStore = 1'b0;
        opSize  = 2'd2;
        case (req_op)
            EXE_LB_OP, EXE_LBU_OP: opSize = 2'd0;
            EXE_LH_OP, EXE_LHU_OP: opSize = 2'd1;
            EXE_LW_OP:             opSize = 2'd2;
            EXE_SB_OP: begin opSize = 2'd0; opStore = 1'b1; end
            EXE_SH_OP: begin opSize = 2'd1; opStore = 1'b1; end
            EXE_SW_OP: begin opSize = 2'd2; opStore = 1'b1; end
            default:               opKnown = 1'b0;
        endcase

        opWdata = req_wdata;
        opWstrb = 4'b0000;
        if (opStore) begin
            case (opSize)
                2'd0: begin
                    opWdata = {4{req_wdata[7:0]}};
                    opWstrb = 4'b0001 << req_addr[1:0];
                end
                2'd1: begin
                    opWdata = {2{req_wdata[15:0]}};
                    opWstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: opWstrb = 4'b1111;
            endcase
        end

        opAddr = req_addr;
        if (KSEG_XLATE != 0 && req_addr[31:30] == 2'b10) begin
            opAddr = {3'b000, req_addr[28:0]};
        end
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign busStart   = accept && opKnown && !misalignTrap;
    assign complete   = data_data_ok &&
                        ((state_q == ADDR && data_addr_ok) || state_q == DATA);

    assign data_req   = (state_q == ADDR);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign stall      = (req_valid && !req_ready) ||
                        (state_q != IDLE && !(state_q == DATA && data_data_ok));

    // Transaction FSM; a flush after launch lets the bus beat finish but swallows the response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            size_q       <= 2'd0;
            wr_q         <= 1'b0;
            kill_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (busStart) begin
                        addr_q  <= opAddr;
                        wdata_q <= opWdata;
                        wstrb_q <= opWstrb;
                        size_q  <= opSize;
                        wr_q    <= opStore;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (data_addr_ok) begin
                        state_q <= data_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (state_q != IDLE && flush) begin
                kill_q <= 1'b1;
            end
            if (complete) begin
                rdata_q      <= data_rdata;
                resp_valid_q <= !(kill_q || flush);
                kill_q       <= 1'b0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic adel_q;
    logic ades_q;

    assign misalignTrap = (opSize == 2'd1 && req_addr[0]) ||
                          (opSize == 2'd2 && req_addr[1:0] != 2'b00);

    // Misaligned accesses never reach the bus; they leave a single-cycle exception pulse instead.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
        end else begin
            adel_q <= accept && opKnown && misalignTrap && !opStore;
            ades_q <= accept && opKnown && misalignTrap && opStore;
        end
    end

    assign adel = adel_q;
    assign ades = ades_q;
`else
    assign misalignTrap = 1'b0;
    assign adel         = 1'b0;
    assign ades         = 1'b0;
`endif

endmodule
